f1_display_ctrl: RTL and testbench



---
 rtl/f1_disp_pkg.sv | 37 +++
 rtl/bin2bcd_seq.sv | 61 ++++++
 rtl/f1_display_ctrl.sv | 119 +++++++++++
 tb/tb_f1_display_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/f1_disp_pkg.sv
// Shared definitions for the F1 start-lights 7-segment display controller.
//   - Decoder codes for the non-hex glyphs used by the message patterns.
//   - Message identifiers and controller state encoding.
//   - Four-entry message pattern table (digit3..digit0, 5 bits each).
package f1_disp_pkg;

    localparam logic [4:0] CODE_T     = 5'h10;
    localparam logic [4:0] CODE_L     = 5'h11;
    localparam logic [4:0] CODE_R     = 5'h12;
    localparam logic [4:0] CODE_G     = 5'h1B;
    localparam logic [4:0] CODE_BLANK = 5'h17;

    localparam logic [19:0] ALL_BLANK = {4{CODE_BLANK}};

    typedef enum logic [1:0] {
        MSG_BLANK = 2'd0,
        MSG_READ  = 2'd1,
        MSG_LATE  = 2'd2,
        MSG_BEST  = 2'd3
    } msg_id_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CONVERT   = 2'd1,
        ST_SHOW_TIME = 2'd2,
        ST_SHOW_MSG  = 2'd3
    } state_e;

    // Indexed by msg_id; "E" and "A" reuse the hex codes, "S" reuses 5.
    localparam logic [19:0] MSG_PAT [4] = '{
        ALL_BLANK,
        {CODE_R, 5'h0E, 5'h0A, 5'h0D},
        {CODE_L, 5'h0A, CODE_T, 5'h0E},
        {5'h0B,  5'h0E, 5'h05, CODE_T}
    };

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: 14-bit binary to four BCD nibbles.
//   clk, rst  : clock, asynchronous active-high reset
//   start_i   : load bin_i and begin a 14-iteration conversion
//   abort_i   : synchronous abort, discards any conversion in progress
//   bin_i     : binary operand (0..16383, caller saturates to 9999)
//   done_o    : high during the cycle whose closing edge runs the last iteration
//   bcd_o     : result valid whenever done_o is high (thousands in [15:12])
// The result is presented combinationally alongside done_o so the caller can
// capture it on the same edge that completes the 14th iteration.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [13:0] bin_i,
    output logic        done_o,
    output logic [15:0] bcd_o
);

    logic [13:0] bin_q;
    logic [15:0] bcd_q;
    logic [15:0] bcd_adj;
    logic [15:0] bcd_d;
    logic [3:0]  cnt_q;
    logic        active_q;

    // Add-3 correction on every nibble that would overflow past 9 when doubled.
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                    bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end

    assign bcd_d  = {bcd_adj[14:0], bin_q[13]};
    assign done_o = active_q && (cnt_q == 4'd13);
    assign bcd_o  = bcd_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (abort_i) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (start_i) begin
            bin_q    <= bin_i;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            bin_q <= {bin_q[12:0], 1'b0};
            bcd_q <= bcd_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd13) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/f1_display_ctrl.sv
// Display sequencer for the 4-digit 7-segment bank of the F1 start-lights game.
// Produces per-digit decoder codes showing either a reaction time (decimal) or
// a fixed text message that auto-blanks after HOLD_TICKS tick_ms pulses.
//   clk, rst    : clock, asynchronous active-high reset
//   tick_ms     : 1 ms enable pulse (only counted while a message is shown)
//   show_time   : strobe, display min(time_ms, TIME_MAX)
//   show_msg    : strobe, display message msg_id
//   clear       : strobe, blank display and abort any conversion
//   digit_code  : digit3 [19:15] .. digit0 [4:0]
//   busy        : conversion in progress, show_* strobes are dropped
//   time_shown  : display holds a valid time
// Build option: define F1_DISP_LZB_EN for leading-zero blanking of times.
module f1_display_ctrl
    import f1_disp_pkg::*;
#(
    parameter int HOLD_TICKS = 3000,
    parameter int TIME_MAX   = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_ms,
    input  logic        show_time,
    input  logic [15:0] time_ms,
    input  logic        show_msg,
    input  logic [1:0]  msg_id,
    input  logic        clear,
    output logic [19:0] digit_code,
    output logic        busy,
    output logic        time_shown
);

    localparam int CW = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);

    state_e      state_q;
    logic [19:0] digit_q;
    logic        busy_q;
    logic        time_shown_q;
    logic [CW-1:0] hold_q;

    logic [13:0] operand;
    logic        conv_start;
    logic        conv_done;
    logic [15:0] conv_bcd;
    logic [19:0] time_digits;

    assign operand    = (time_ms > 16'(TIME_MAX)) ? 14'(TIME_MAX) : time_ms[13:0];
    assign conv_start = show_time && !busy_q && !clear;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (conv_start),
        .abort_i (clear),
        .bin_i   (operand),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_comb begin
        time_digits = {1'b0, conv_bcd[15:12], 1'b0, conv_bcd[11:8],
                       1'b0, conv_bcd[7:4],   1'b0, conv_bcd[3:0]};
`ifdef F1_DISP_LZB_EN
        // Blank zeros left of the most significant non-zero digit; digit0 stays.
        if (conv_bcd[15:12] == 4'd0) begin
            time_digits[19:15] = CODE_BLANK;
            if (conv_bcd[11:8] == 4'd0) begin
                time_digits[14:10] = CODE_BLANK;
                if (conv_bcd[7:4] == 4'd0) begin
                    time_digits[9:5] = CODE_BLANK;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            digit_q      <= ALL_BLANK;
            busy_q       <= 1'b0;
            time_shown_q <= 1'b0;
            hold_q       <= '0;
        end else if (clear) begin
            state_q      <= ST_IDLE;
            digit_q      <= ALL_BLANK;
            busy_q       <= 1'b0;
            time_shown_q <= 1'b0;
            hold_q       <= '0;
        end else if (state_q == ST_CONVERT) begin
            // Display keeps its old content until the result lands.
            if (conv_done) begin
                digit_q      <= time_digits;
                state_q      <= ST_SHOW_TIME;
                time_shown_q <= 1'b1;
                busy_q       <= 1'b0;
            end
        end else if (show_time) begin
            state_q <= ST_CONVERT;
            busy_q  <= 1'b1;
        end else if (show_msg) begin
            digit_q      <= MSG_PAT[msg_id];
            time_shown_q <= 1'b0;
            hold_q       <= '0;
            state_q      <= (msg_id_e'(msg_id) == MSG_BLANK) ? ST_IDLE : ST_SHOW_MSG;
        end else if (state_q == ST_SHOW_MSG) begin
            if ((HOLD_TICKS != 0) && (hold_q == CW'(HOLD_TICKS))) begin
                digit_q <= ALL_BLANK;
                state_q <= ST_IDLE;
            end else if (tick_ms) begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign digit_code = digit_q;
    assign busy       = busy_q;
    assign time_shown = time_shown_q;

endmodule

// File: tb/tb_f1_display_ctrl.sv
module tb_f1_display_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_ms;
    logic        show_time;
    logic [15:0] time_ms;
    logic        show_msg;
    logic [1:0]  msg_id;
    logic        clear;
    logic [19:0] digit_code;
    logic        busy;
    logic        time_shown;

    int tests = 0;
    int fails = 0;
    int n;

    localparam logic [19:0] BLANK = {4{5'h17}};

    f1_display_ctrl #(.HOLD_TICKS(4), .TIME_MAX(9999)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_ms    (tick_ms),
        .show_time  (show_time),
        .time_ms    (time_ms),
        .show_msg   (show_msg),
        .msg_id     (msg_id),
        .clear      (clear),
        .digit_code (digit_code),
        .busy       (busy),
        .time_shown (time_shown)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Strobe show_time for one edge, then count edges until busy falls.
    task automatic run_time(input logic [15:0] t);
        time_ms   = t;
        show_time = 1'b1;
        step();
        show_time = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic send_msg(input logic [1:0] id);
        msg_id   = id;
        show_msg = 1'b1;
        step();
        show_msg = 1'b0;
    endtask

    task automatic tick();
        tick_ms = 1'b1;
        step();
        tick_ms = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick_ms = 0; show_time = 0; time_ms = 0;
        show_msg = 0; msg_id = 0; clear = 0;
        step(); step();
        check("reset_digits", digit_code, BLANK);
        check("reset_busy", {19'd0, busy}, 20'd0);
        check("reset_time_shown", {19'd0, time_shown}, 20'd0);
        rst = 1'b0;
        step();

        // 1234: 14-cycle busy, then all four digits
        run_time(16'd1234);
        check("t1234_busy_cycles", 20'(n), 20'd14);
        check("t1234_digits", digit_code, {5'h01, 5'h02, 5'h03, 5'h04});
        check("t1234_time_shown", {19'd0, time_shown}, 20'd1);

        // tick has no effect in SHOW_TIME
        for (int i = 0; i < 6; i++) tick();
        check("t1234_ticks_hold", digit_code, {5'h01, 5'h02, 5'h03, 5'h04});

        run_time(16'd65535);
        check("t65535_saturate", digit_code, {5'h09, 5'h09, 5'h09, 5'h09});

        run_time(16'd7);
`ifdef F1_DISP_LZB_EN
        check("t7_digits", digit_code, {5'h17, 5'h17, 5'h17, 5'h07});
`else
        check("t7_digits", digit_code, {5'h00, 5'h00, 5'h00, 5'h07});
`endif

        run_time(16'd0);
`ifdef F1_DISP_LZB_EN
        check("t0_digits", digit_code, {5'h17, 5'h17, 5'h17, 5'h00});
`else
        check("t0_digits", digit_code, 20'd0);
`endif

        // Messages
        send_msg(2'd1);
        check("msg1_pattern", digit_code, {5'h12, 5'h0E, 5'h0A, 5'h0D});
        check("msg1_time_shown", {19'd0, time_shown}, 20'd0);
        send_msg(2'd3);
        check("msg3_pattern", digit_code, {5'h0B, 5'h0E, 5'h05, 5'h10});
        send_msg(2'd0);
        check("msg0_blank", digit_code, BLANK);

        // Hold timeout with restart at tick 3
        send_msg(2'd2);
        check("msg2_pattern", digit_code, {5'h11, 5'h0A, 5'h10, 5'h0E});
        for (int i = 0; i < 3; i++) tick();
        send_msg(2'd2);
        for (int i = 0; i < 3; i++) tick();
        step();
        check("msg2_restart_3ticks", digit_code, {5'h11, 5'h0A, 5'h10, 5'h0E});
        tick();
        check("msg2_after_4th_tick", digit_code, {5'h11, 5'h0A, 5'h10, 5'h0E});
        step();
        check("msg2_timeout_blank", digit_code, BLANK);
        for (int i = 0; i < 5; i++) tick();
        check("idle_ticks_blank", digit_code, BLANK);

        // show_time and show_msg together: time wins; show_msg during busy dropped
        time_ms = 16'd42; msg_id = 2'd1;
        show_time = 1'b1; show_msg = 1'b1;
        step();
        show_time = 1'b0; show_msg = 1'b0;
        check("both_busy", {19'd0, busy}, 20'd1);
        check("both_digits_kept", digit_code, BLANK);
        step();
        msg_id = 2'd3; show_msg = 1'b1;
        step();
        show_msg = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
`ifdef F1_DISP_LZB_EN
        check("t42_final", digit_code, {5'h17, 5'h17, 5'h04, 5'h02});
`else
        check("t42_final", digit_code, {5'h00, 5'h00, 5'h04, 5'h02});
`endif
        check("t42_time_shown", {19'd0, time_shown}, 20'd1);

        // clear at cycle 7 of a conversion
        time_ms = 16'd1234; show_time = 1'b1;
        step();
        show_time = 1'b0;
        for (int i = 0; i < 6; i++) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_blank", digit_code, BLANK);
        check("clear_busy", {19'd0, busy}, 20'd0);
        check("clear_time_shown", {19'd0, time_shown}, 20'd0);
        for (int i = 0; i < 20; i++) step();
        check("clear_no_late_update", digit_code, BLANK);

        // Asynchronous reset in the middle of a conversion
        run_time(16'd1234);
        time_ms = 16'd5678; show_time = 1'b1;
        step();
        show_time = 1'b0;
        step(); step();
        #2 rst = 1'b1;
        #1;
        check("async_rst_digits", digit_code, BLANK);
        check("async_rst_busy", {19'd0, busy}, 20'd0);
        step();
        rst = 1'b0;
        step();
        run_time(16'd5678);
        check("after_rst_5678", digit_code, {5'h05, 5'h06, 5'h07, 5'h08});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
